sfx_scheduler: RTL

SFX_SCHEDULER -- requirements
Module: sfx_scheduler

---
 rtl/sfx_pkg.sv | 16 +
 rtl/sfx_prio_enc.sv | 18 +
 rtl/sfx_scheduler.sv | 109 ++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and constants for the sound-effect scheduler
// FSM state enum, Avalon register map and status-word bit positions.
// ABORT exists only when SFX_SCHEDULER_PREEMPT_EN is defined.
package sfx_pkg;
`ifdef SFX_SCHEDULER_PREEMPT_EN
  typedef enum logic [1:0] {IDLE, PLAY, ABORT, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
`endif
  localparam logic REG_MASK   = 1'b0;
  localparam logic REG_STATUS = 1'b1;
  localparam int   ST_BUSY    = 31;
  localparam int   ST_CUR     = 16;
  localparam int   ST_PEND    = 0;
  localparam int   ID_W       = 2;
endpackage

// File: rtl/sfx_prio_enc.sv
// sfx_prio_enc: lowest-index-first priority encoder
// vec_i : request vector; vld_o : any bit set; idx_o : lowest set index
module sfx_prio_enc
  import sfx_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] vec_i,
  output logic               vld_o,
  output logic [ID_W-1:0]    idx_o
);
  assign vld_o = |vec_i;
  always_comb begin
    idx_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (vec_i[i]) idx_o = ID_W'(i);
  end
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: priority scheduler driving an I2S clip player
// CLK/RESET       : clock, asynchronous active-high reset
// req             : per-source request pulses (index 0 = highest priority)
// play_done       : end-of-clip pulse from the player
// play_start      : play level to player; play_sel : clip index
// busy            : high whenever not IDLE
// AVL_*           : Avalon-MM slave, addr 0 = mask (RW), addr 1 = status (RO)
// SFX_SCHEDULER_PREEMPT_EN : a higher-priority request aborts the running clip
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] req,
  input  logic               play_done,
  output logic               play_start,
  output logic [1:0]         play_sel,
  output logic               busy,
  input  logic               AVL_READ,
  input  logic               AVL_WRITE,
  input  logic               AVL_CS,
  input  logic               AVL_ADDR,
  input  logic [31:0]        AVL_WRITEDATA,
  output logic [31:0]        AVL_READDATA
);
  localparam int GW = GAP_CYCLES > 2 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] pending_q, pending_d, mask_q, mask_d, clr;
  logic [ID_W-1:0] cur_id_q, cur_id_d, grant_idx;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic grant_v;
  logic unused_wdata;
  assign unused_wdata = &{1'b0, AVL_WRITEDATA[31:NUM_SRC]};
  sfx_prio_enc #(.NUM_SRC(NUM_SRC)) u_enc (
    .vec_i(pending_q & mask_q),
    .vld_o(grant_v),
    .idx_o(grant_idx)
  );
  assign play_start   = state_q == PLAY;
  assign play_sel     = cur_id_q;
  assign busy         = state_q != IDLE;
  assign AVL_READDATA = rdata_q;
  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    gap_d    = gap_q;
    clr      = '0;
    case (state_q)
`ifdef SFX_SCHEDULER_PREEMPT_EN
      IDLE, ABORT: begin
`else
      IDLE: begin
`endif
        state_d = IDLE;
        if (grant_v) begin
          clr      = NUM_SRC'(1) << grant_idx;
          cur_id_d = grant_idx;
          state_d  = PLAY;
        end
      end
      PLAY: begin
        if (play_done) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
`ifdef SFX_SCHEDULER_PREEMPT_EN
        else if (grant_v && grant_idx < cur_id_q) state_d = ABORT;
`endif
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // the request OR follows the grant clear so a coincident re-request survives
  assign mask_d    = (AVL_WRITE && AVL_CS && AVL_ADDR == REG_MASK) ? AVL_WRITEDATA[NUM_SRC-1:0] : mask_q;
  assign pending_d = ((pending_q & ~clr) | req) & mask_d;
  always_comb begin
    status                     = '0;
    status[ST_BUSY]            = busy;
    status[ST_CUR +: ID_W]     = cur_id_q;
    status[ST_PEND +: NUM_SRC] = pending_q;
    rdata_d = (AVL_READ && AVL_CS) ? (AVL_ADDR == REG_STATUS ? status : 32'(mask_q)) : rdata_q;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '1;
      cur_id_q  <= '0;
      gap_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cur_id_q  <= cur_id_d;
      gap_q     <= gap_d;
      rdata_q   <= rdata_d;
    end
  end
endmodule
